// File: rtl/seven_seg_pkg.sv
// Shared segment-code types and scanner state encoding for the display path.
package seven_seg_pkg;

  localparam int unsigned SEG_W = 7;

  typedef logic [SEG_W-1:0] seg_code_t;

  // Bit positions of each segment within a seg_code_t.
  localparam int unsigned SEG_A = 6;
  localparam int unsigned SEG_B = 5;
  localparam int unsigned SEG_C = 4;
  localparam int unsigned SEG_D = 3;
  localparam int unsigned SEG_E = 2;
  localparam int unsigned SEG_F = 1;
  localparam int unsigned SEG_G = 0;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } scan_state_t;

endpackage

// File: rtl/scan_dwell_timer.sv
// Dwell counter for one digit slot: counts 0..COUNT-1, wraps, flags the last cycle.
module scan_dwell_timer #(
  parameter int unsigned COUNT = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     clear_i,
  input  logic                     run_i,
  output logic [$clog2(COUNT)-1:0] count_o,
  output logic                     wrap_o
);

  localparam int unsigned CW = $clog2(COUNT);

  logic [CW-1:0] count_q, count_d;
  logic          wrap_q, wrap_d;

  // Next count; the wrap flag is registered alongside so it marks count == COUNT-1.
  always_comb begin
    count_d = count_q;
    if (clear_i) begin
      count_d = '0;
    end else if (run_i) begin
      count_d = wrap_q ? '0 : count_q + CW'(1);
    end
    wrap_d = (count_d == CW'(COUNT - 1));
  end

  // Counter and terminal-count registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
      wrap_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      wrap_q  <= wrap_d;
    end
  end

  assign count_o = count_q;
  assign wrap_o  = wrap_q;

endmodule

// File: rtl/seven_segment_scanner.sv
// Time-multiplexes a frame-latched array of segment codes onto one segment bus
// with one-hot digit enables and a blank interval at the start of each slot.
module seven_segment_scanner
  import seven_seg_pkg::*;
#(
  parameter int unsigned DISPLAY_WIDTH  = 12,
  parameter int unsigned CLKS_PER_DIGIT = 16,
  parameter int unsigned BLANK_CLKS     = 2,
  parameter bit          ACTIVE_LOW     = 1'b0
) (
  input  logic                                 clk,
  input  logic                                 reset,
  input  logic [DISPLAY_WIDTH-1:0][6:0]        seven_segment_array,
  input  logic                                 enable,
  output logic [6:0]                           segment_out,
  output logic [DISPLAY_WIDTH-1:0]             digit_enable,
  output logic [$clog2(DISPLAY_WIDTH)-1:0]     digit_index,
  output logic                                 frame_start
);

  localparam int unsigned IW = $clog2(DISPLAY_WIDTH);
  localparam int unsigned CW = $clog2(CLKS_PER_DIGIT);
  localparam logic [IW-1:0] LAST_IDX = IW'(DISPLAY_WIDTH - 1);
  localparam scan_state_t SLOT_START = (BLANK_CLKS == 0) ? SHOW : BLANK;
  localparam seg_code_t SEG_OFF = {SEG_W{ACTIVE_LOW}};
  localparam logic [DISPLAY_WIDTH-1:0] DEN_OFF = {DISPLAY_WIDTH{ACTIVE_LOW}};

  scan_state_t                   state_q, state_d;
  logic [IW-1:0]                 idx_q, idx_d;
  seg_code_t [DISPLAY_WIDTH-1:0] snap_q, snap_d;
  seg_code_t                     seg_q, seg_d;
  logic [DISPLAY_WIDTH-1:0]      den_q, den_d;
  logic                          fs_q, fs_d;

  logic [CW-1:0] dwell;
  logic          dwell_wrap;
  logic          dwell_clear_c;
  logic          dwell_run_c;

  scan_dwell_timer #(
    .COUNT (CLKS_PER_DIGIT)
  ) u_dwell (
    .clk     (clk),
    .reset   (reset),
    .clear_i (dwell_clear_c),
    .run_i   (dwell_run_c),
    .count_o (dwell),
    .wrap_o  (dwell_wrap)
  );

  // Next state, slot index, snapshot and the logical outputs for the next cycle.
  always_comb begin
    state_d       = state_q;
    idx_d         = idx_q;
    snap_d        = snap_q;
    fs_d          = 1'b0;
    dwell_clear_c = 1'b0;
    dwell_run_c   = 1'b0;
    seg_d         = '0;
    den_d         = '0;

    unique case (state_q)
      IDLE: begin
        dwell_clear_c = 1'b1;
        if (enable) begin
          state_d = SLOT_START;
          idx_d   = LAST_IDX;
          snap_d  = seven_segment_array;
          fs_d    = 1'b1;
        end
      end
      BLANK, SHOW: begin
        if (!enable) begin
          state_d       = IDLE;
          idx_d         = LAST_IDX;
          dwell_clear_c = 1'b1;
        end else begin
          dwell_run_c = 1'b1;
          if (dwell_wrap) begin
            state_d = SLOT_START;
            if (idx_q == '0) begin
              idx_d  = LAST_IDX;
              snap_d = seven_segment_array;
              fs_d   = 1'b1;
            end else begin
              idx_d = idx_q - IW'(1);
            end
          end else begin
            state_d = ((32'(dwell) + 32'd1) >= BLANK_CLKS) ? SHOW : BLANK;
          end
        end
      end
      default: begin
        state_d       = IDLE;
        idx_d         = LAST_IDX;
        dwell_clear_c = 1'b1;
      end
    endcase

    if (state_d == SHOW) begin
      seg_d = snap_d[idx_d];
      den_d = DISPLAY_WIDTH'(1) << idx_d;
    end
  end

  // State, index, snapshot and output registers; polarity applied at the output.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      idx_q   <= LAST_IDX;
      snap_q  <= '0;
      seg_q   <= SEG_OFF;
      den_q   <= DEN_OFF;
      fs_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      snap_q  <= snap_d;
      seg_q   <= ACTIVE_LOW ? ~seg_d : seg_d;
      den_q   <= ACTIVE_LOW ? ~den_d : den_d;
      fs_q    <= fs_d;
    end
  end

  assign segment_out  = seg_q;
  assign digit_enable = den_q;
  assign digit_index  = idx_q;
  assign frame_start  = fs_q;

endmodule

// File: tb/tb_seven_segment_scanner.sv
// Bench for seven_segment_scanner: three parameterisations share one stimulus
// stream; a slot-position model predicts every cycle's outputs.
module tb_seven_segment_scanner;
  import seven_seg_pkg::*;

  localparam int unsigned W = 4;
  localparam int unsigned C = 4;

  logic                clk = 1'b0;
  logic                reset;
  logic                enable;
  logic [W-1:0][6:0]   arr;

  logic [6:0]   seg0, seg1, seg2;
  logic [W-1:0] den0, den1, den2;
  logic [1:0]   idx0, idx1, idx2;
  logic         fs0, fs1, fs2;

  always #5 clk = ~clk;

  seven_segment_scanner #(.DISPLAY_WIDTH(W), .CLKS_PER_DIGIT(C), .BLANK_CLKS(1), .ACTIVE_LOW(1'b0)) u_base (
    .clk(clk), .reset(reset), .seven_segment_array(arr), .enable(enable),
    .segment_out(seg0), .digit_enable(den0), .digit_index(idx0), .frame_start(fs0));

  seven_segment_scanner #(.DISPLAY_WIDTH(W), .CLKS_PER_DIGIT(C), .BLANK_CLKS(1), .ACTIVE_LOW(1'b1)) u_low (
    .clk(clk), .reset(reset), .seven_segment_array(arr), .enable(enable),
    .segment_out(seg1), .digit_enable(den1), .digit_index(idx1), .frame_start(fs1));

  seven_segment_scanner #(.DISPLAY_WIDTH(W), .CLKS_PER_DIGIT(C), .BLANK_CLKS(0), .ACTIVE_LOW(1'b0)) u_nob (
    .clk(clk), .reset(reset), .seven_segment_array(arr), .enable(enable),
    .segment_out(seg2), .digit_enable(den2), .digit_index(idx2), .frame_start(fs2));

  typedef struct packed {
    logic [2:0][6:0]   seg;
    logic [2:0][W-1:0] den;
    logic [2:0][1:0]   idx;
    logic [2:0]        fs;
  } exp_t;

  exp_t              sb[$];
  int                errors = 0;
  int                checks = 0;
  bit                running = 1'b0;
  int unsigned       t = 0;
  logic [W-1:0][6:0] snap = '0;

  // Model of the scanner state after the coming edge: position t within the frame.
  task automatic model_edge();
    if (reset) begin
      running = 1'b0; t = 0; snap = '0;
    end else if (!enable) begin
      running = 1'b0; t = 0;
    end else if (!running) begin
      running = 1'b1; t = 0; snap = arr;
    end else begin
      t = t + 1;
      if (t == W * C) begin
        t = 0; snap = arr;
      end
    end
  endtask

  function automatic exp_t model_out();
    exp_t        e;
    int unsigned pos, dig, blank;
    bit          lit;
    pos = t % C;
    dig = W - 1 - (t / C);
    for (int i = 0; i < 3; i++) begin
      blank = (i == 2) ? 0 : 1;
      lit = running && (pos >= blank);
      e.seg[i] = lit ? snap[dig] : 7'h00;
      e.den[i] = lit ? (W'(1) << dig) : '0;
      if (i == 1) begin
        e.seg[i] = ~e.seg[i];
        e.den[i] = ~e.den[i];
      end
      e.idx[i] = running ? 2'(dig) : 2'(W - 1);
      e.fs[i]  = running && (t == 0);
    end
    return e;
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s t=%0d got=%h exp=%h", tag, t, got, exp);
    end
  endtask

  // Drive one edge: push the prediction, then pop and compare after the edge.
  task automatic step();
    exp_t e;
    model_edge();
    sb.push_back(model_out());
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("base_seg", 32'(seg0), 32'(e.seg[0]));
    chk("base_den", 32'(den0), 32'(e.den[0]));
    chk("base_idx", 32'(idx0), 32'(e.idx[0]));
    chk("base_fs",  32'(fs0),  32'(e.fs[0]));
    chk("low_seg",  32'(seg1), 32'(e.seg[1]));
    chk("low_den",  32'(den1), 32'(e.den[1]));
    chk("low_idx",  32'(idx1), 32'(e.idx[1]));
    chk("low_fs",   32'(fs1),  32'(e.fs[1]));
    chk("nob_seg",  32'(seg2), 32'(e.seg[2]));
    chk("nob_den",  32'(den2), 32'(e.den[2]));
    chk("nob_idx",  32'(idx2), 32'(e.idx[2]));
    chk("nob_fs",   32'(fs2),  32'(e.fs[2]));
  endtask

  task automatic run_to(input int unsigned target);
    for (int n = 0; n < 200 && t != target; n++) step();
    chk("run_to_reached", 32'(t), 32'(target));
  endtask

  initial begin
    reset = 1'b1; enable = 1'b0; arr = '0;
    for (int i = 0; i < 3; i++) step();
    chk("rst_seg", 32'(seg0), 32'h00);
    chk("rst_idx", 32'(idx0), 32'd3);
    chk("rst_low_seg", 32'(seg1), 32'h7F);
    reset = 1'b0;
    for (int i = 0; i < 20; i++) step();
    chk("idle_den", 32'(den0), 32'h0);
    chk("idle_fs", 32'(fs0), 32'h0);

    // Basic scan of "1234".
    arr = {7'h30, 7'h6D, 7'h79, 7'h33};
    enable = 1'b1;
    step();
    chk("start_fs", 32'(fs0), 32'h1);
    chk("start_blank_den", 32'(den0), 32'h0);
    chk("start_low_seg", 32'(seg1), 32'h7F);
    chk("start_low_den", 32'(den1), 32'hF);
    chk("nob_first_den", 32'(den2), 32'h8);
    chk("nob_first_seg", 32'(seg2), 32'h30);
    step();
    chk("d3_den", 32'(den0), 32'h8);
    chk("d3_seg", 32'(seg0), 32'h30);
    chk("low_d3_seg", 32'(seg1), 32'h4F);
    chk("low_d3_den", 32'(den1), 32'h7);
    run_to(4);
    chk("d2_blank_den", 32'(den0), 32'h0);
    step();
    chk("d2_den", 32'(den0), 32'h4);
    chk("d2_seg", 32'(seg0), 32'h6D);
    run_to(9);
    chk("d1_seg", 32'(seg0), 32'h79);
    chk("d1_den", 32'(den0), 32'h2);
    run_to(13);
    chk("d0_seg", 32'(seg0), 32'h33);
    chk("d0_den", 32'(den0), 32'h1);
    run_to(0);
    chk("frame2_fs", 32'(fs0), 32'h1);

    // Mid-frame input change is held off until the next frame.
    step();
    arr[1] = 7'h7F;
    run_to(9);
    chk("snap_old", 32'(seg0), 32'h79);
    run_to(0);
    run_to(9);
    chk("snap_new", 32'(seg0), 32'h7F);

    // Enable drop during digit 2's lit slot, then re-enable.
    run_to(5);
    chk("pre_drop_den", 32'(den0), 32'h4);
    enable = 1'b0;
    step();
    chk("drop_idx", 32'(idx0), 32'd3);
    chk("drop_den", 32'(den0), 32'h0);
    chk("drop_seg", 32'(seg0), 32'h00);
    enable = 1'b1;
    step();
    chk("reen_fs", 32'(fs0), 32'h1);
    chk("reen_idx", 32'(idx0), 32'd3);
    step();
    chk("reen_den", 32'(den0), 32'h8);

    // Reset while lit, then back-to-back slots with no blank interval.
    reset = 1'b1;
    step();
    chk("rst_show_den", 32'(den0), 32'h0);
    chk("rst_show_seg", 32'(seg0), 32'h00);
    chk("rst_show_nob_den", 32'(den2), 32'h0);
    reset = 1'b0;
    step();
    chk("nob_restart_den", 32'(den2), 32'h8);
    run_to(3);
    chk("nob_d3_end", 32'(den2), 32'h8);
    step();
    chk("nob_d2_den", 32'(den2), 32'h4);
    chk("nob_d2_seg", 32'(seg2), 32'h6D);
    for (int i = 0; i < 6; i++) step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/seven_segment_scanner.md
Name: seven_segment_scanner

Overview:
Downstream display stage for the floating-point converter. It consumes the parallel seven_segment_array (one 7-bit code per digit) and time-multiplexes it onto one shared segment bus plus per-digit enables, for driving a physical multiplexed LED display. The block adds an anti-ghosting blank interval between digits. It latches the array once per frame so the display never tears.

Parameters:
DISPLAY_WIDTH, 12, number of digits; index DISPLAY_WIDTH-1 is the leftmost digit.
CLKS_PER_DIGIT, 16, clock cycles each digit slot lasts, including the blank interval; must be >= 2.
BLANK_CLKS, 2, cycles at the start of each slot with all outputs off; 0 <= BLANK_CLKS < CLKS_PER_DIGIT.
ACTIVE_LOW, 0, when 1, segment_out and digit_enable are inverted at the output register.

Ports:
clk  input  1  system clock; single clock domain.
reset  input  1  synchronous, active-high reset.
seven_segment_array  input  [DISPLAY_WIDTH-1:0][6:0]  segment codes. Bit 6=A, 5=B, 4=C, 3=D, 2=E, 1=F, 0=G; a 1 lights the segment.
enable  input  1  1 = scan; 0 = go dark.
segment_out  output  7  segment bus, same bit order as the input.
digit_enable  output  DISPLAY_WIDTH  one-hot digit select; bit i drives digit i.
digit_index  output  $clog2(DISPLAY_WIDTH)  index of the digit slot currently scanned.
frame_start  output  1  one-cycle pulse when a new frame begins and the snapshot loads.

Behaviour:
- All outputs are registered. Values below are logical; ACTIVE_LOW inverts segment_out and digit_enable only.
- Reset (synchronous, dominates enable):
  - state=IDLE, dwell_cnt=0, digit_index=DISPLAY_WIDTH-1, snapshot=0.
  - Outputs: segment_out=0, digit_enable=0, frame_start=0.
- States are IDLE, BLANK and SHOW.
  - IDLE: outputs off. Let edge k be the first edge with enable=1. After edge k:
    - snapshot<=seven_segment_array, digit_index=DISPLAY_WIDTH-1, dwell_cnt=0, frame_start=1.
    - State becomes BLANK, or SHOW if BLANK_CLKS==0.
  - BLANK: segment_out=0, digit_enable=0 while dwell_cnt < BLANK_CLKS.
  - SHOW: digit_enable=one-hot(digit_index) and segment_out=snapshot[digit_index] while BLANK_CLKS <= dwell_cnt <= CLKS_PER_DIGIT-1.
- dwell_cnt increments every cycle. At CLKS_PER_DIGIT-1 it wraps to 0 and the next slot starts in BLANK.
  - digit_index decrements at the wrap.
  - After index 0, the next index is DISPLAY_WIDTH-1. This edge also reloads the snapshot and pulses frame_start for one cycle.
- Timing:
  - Frame period = DISPLAY_WIDTH*CLKS_PER_DIGIT cycles.
  - The first lit digit appears after edge k+BLANK_CLKS.
  - frame_start is high exactly once per frame.
- Input changes mid-frame are invisible until the next frame_start.
- enable=0 sampled in BLANK or SHOW: after that edge, state=IDLE, outputs off, digit_index=DISPLAY_WIDTH-1, dwell_cnt=0, and the snapshot is held. Re-enable restarts a full frame from the leftmost digit.
- Reset mid-SHOW: outputs are off after that edge. No partial-slot resume.
- digit_enable is never multi-hot. segment_out is 0 whenever digit_enable is 0.

Decomposition:
- Package seven_seg_pkg holds:
  - typedef seg_code_t = logic [6:0].
  - Constants SEG_A=6, SEG_B=5, SEG_C=4, SEG_D=3, SEG_E=2, SEG_F=1, SEG_G=0.
  - enum scan_state_t {IDLE, BLANK, SHOW}.
  - Shared with the converter and the bench's display task.
- One sub-module, scan_dwell_timer: parameterised dwell counter with synchronous clear and terminal-count (wrap) output.
- The FSM, index counter, snapshot and output registers stay in the top module.

Test Plan:
- Common setup for scenarios 1-3, 5 and 6: DISPLAY_WIDTH=4, CLKS_PER_DIGIT=4, BLANK_CLKS=1, ACTIVE_LOW=0.
- Reset/idle, common setup, reset for 3 cycles then enable=0 for 20 cycles -> segment_out=0, digit_enable=4'b0000, frame_start=0 throughout.
- Basic scan, common setup, array={7'h30,7'h6D,7'h79,7'h33} ("1234"), enable=1 at edge k -> frame_start=1 after edge k. Each slot is blank 1 cycle, then lit 3 cycles. Expected order: (1000,30), (0100,6D), (0010,79), (0001,33). frame_start repeats every 16 cycles.
- Snapshot, common setup, change array[1] to 7'h7F during the slot for digit 3 -> digit 1 still shows 7'h79 this frame and shows 7'h7F after the next frame_start.
- Polarity, ACTIVE_LOW=1, otherwise the basic-scan setup -> blank cycles drive segment_out=7'h7F and digit_enable=4'b1111. The digit-3 lit slot drives segment_out=7'h4F and digit_enable=4'b0111.
- Enable drop and re-enable, common setup, enable=0 during the lit slot of digit 2 -> outputs off and digit_index=3 after that edge. Re-enable gives frame_start and restarts at digit 3.
- Reset mid-SHOW and BLANK_CLKS=0:
  - Reset asserted during a lit slot -> all outputs 0 after that edge.
  - With BLANK_CLKS=0, digit 3 is lit immediately after edge k, and consecutive slots are lit back-to-back.
